sw_debounce_ctrl: RTL

Avalon-MM slave controller for the board slide switches. Synchronises and debounces the raw 8-bit switch bus, then exposes the debounced state over a 2-bit word-addressed register file. Detects selected edges into a sticky, write-1-to-clear capture register and drives a maskable level interrupt to the HPS/FPGA interrupt controller. Sits between the switch pins and the Avalon interconnect, where a plain input PIO would otherwise sit.

---
 rtl/sw_debounce_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/sw_debounce_ctrl.sv
// Avalon-MM slide-switch controller: synchronises and debounces the switch bus,
// captures selected edges into a sticky W1C register and raises a maskable level irq.
`timescale 1ns/1ps
module sw_debounce_ctrl #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned TICK_DIV       = 50000,
  parameter int unsigned DEBOUNCE_TICKS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int unsigned EW = 2 * WIDTH;

  localparam logic [PW-1:0] TICK_LAST     = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST      = CW'(DEBOUNCE_TICKS - 1);
  localparam logic [EW-1:0] EDGE_EN_RESET = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_MASK    = 2'd1;
  localparam logic [1:0] ADDR_CAPTURE = 2'd2;
  localparam logic [1:0] ADDR_EDGE_EN = 2'd3;

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [PW-1:0]    r_presc;
  logic [CW-1:0]    r_cnt [WIDTH];
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] r_stable_q;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_capture;
  logic [EW-1:0]    r_edge_en;

  logic             w_tick;
  logic             w_wr_mask;
  logic             w_wr_capture;
  logic             w_wr_edge_en;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rdata;

  // Two-flop synchroniser for the asynchronous switch pins
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

  // Free-running prescaler; tick marks the last count of each period
  assign w_tick = (r_presc == TICK_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Per-bit debounce: any cycle of agreement restarts the mismatch count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stable <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (w_tick) begin
          if (r_cnt[i] == CNT_LAST) begin
            r_stable[i] <= r_sync2[i];
            r_cnt[i]    <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + CW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stable_q <= '0;
    end else begin
      r_stable_q <= r_stable;
    end
  end

  assign w_rise = r_stable & ~r_stable_q & r_edge_en[WIDTH-1:0];
  assign w_fall = ~r_stable & r_stable_q & r_edge_en[EW-1:WIDTH];

  assign w_wr_mask    = write && (address == ADDR_MASK);
  assign w_wr_capture = write && (address == ADDR_CAPTURE);
  assign w_wr_edge_en = write && (address == ADDR_EDGE_EN);
  assign w_clr        = w_wr_capture ? writedata[WIDTH-1:0] : '0;

  // Control registers; a new edge overrides a same-cycle clear of that bit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask    <= '0;
      r_capture <= '0;
      r_edge_en <= EDGE_EN_RESET;
    end else begin
      r_capture <= (r_capture & ~w_clr) | w_rise | w_fall;
      if (w_wr_mask) begin
        r_mask <= writedata[WIDTH-1:0];
      end
      if (w_wr_edge_en) begin
        r_edge_en <= writedata[EW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= |(r_capture & r_mask);
    end
  end

  // Read mux, zero-extended to the bus width
  always_comb begin
    w_rdata = '0;
    unique case (address)
      ADDR_DATA:    w_rdata = 32'(r_stable);
      ADDR_MASK:    w_rdata = 32'(r_mask);
      ADDR_CAPTURE: w_rdata = 32'(r_capture);
      ADDR_EDGE_EN: w_rdata = 32'(r_edge_en);
      default:      w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      readdata <= w_rdata;
    end
  end

endmodule
